// File: rtl/seq_booth_mult.sv
// seq_booth_mult
//   Sequential radix-4 Booth multiplier. Two multiplier bits are retired per
//   clock. The result is a full 2*WIDTH product. Signed/unsigned mode is
//   selected at run time and latched together with the operands.
//
// Parameters
//   WIDTH    operand width (even, >= 4)
//
// Ports
//   CLK      rising-edge clock
//   RST      asynchronous, active-high reset
//   St       start request (level), only sampled while idle
//   Signed   1 = two's-complement operands, 0 = unsigned (latched at load)
//   Mplier   multiplier (latched at load)
//   Mcand    multiplicand (latched at load)
//   Busy     high while a multiply is iterating
//   Done     high while the finished result is being presented
//   Product  result register, held until the next completion
module seq_booth_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 St,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     Mplier,
  input  logic [WIDTH-1:0]     Mcand,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  // One iteration per pair of multiplier bits, plus one extra iteration.
  // The extra iteration covers the two extension bits, which keeps the
  // unsigned case exact.
  localparam int NIT = WIDTH/2 + 1;
  localparam int CW  = $clog2(NIT);
  localparam int AW  = WIDTH + 3;   // accumulator / multiplicand width
  localparam int QW  = WIDTH + 2;   // multiplier shift register width

  localparam logic [CW-1:0] CNT_LAST = CW'(NIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [AW-1:0]   a_r;
  logic [AW-1:0]   m_r;
  logic [QW-1:0]   q_r;
  logic            qm1_r;
  logic [CW-1:0]   cnt_r;

  logic [AW-1:0]   mcand_ext_s;
  logic [QW-1:0]   mplier_ext_s;
  logic [AW-1:0]   sum_s;
  logic [AW-1:0]   a_shift_s;
  logic [QW-1:0]   q_shift_s;
  logic            qm1_shift_s;

  // Booth recoding of {Q1,Q0,Q-1} into the addend 0, +-M or +-2M
  // (all arithmetic is modulo 2^AW).
  function automatic logic [AW-1:0] booth_addend(input logic [2:0] code,
                                                 input logic [AW-1:0] m);
    logic [AW-1:0] m2;
    m2 = {m[AW-2:0], 1'b0};
    case (code)
      3'b000, 3'b111: booth_addend = {AW{1'b0}};
      3'b001, 3'b010: booth_addend = m;
      3'b011:         booth_addend = m2;
      3'b100:         booth_addend = {AW{1'b0}} - m2;
      3'b101, 3'b110: booth_addend = {AW{1'b0}} - m;
      default:        booth_addend = {AW{1'b0}};
    endcase
  endfunction

  // Operand extension at load time (sign or zero, per Signed).
  always_comb begin
    mcand_ext_s  = {{3{Signed & Mcand[WIDTH-1]}}, Mcand};
    mplier_ext_s = {{2{Signed & Mplier[WIDTH-1]}}, Mplier};
  end

  // One Booth step: add the recoded addend, then arithmetic shift {A,Q,Q-1} by 2.
  always_comb begin
    sum_s       = a_r + booth_addend({q_r[1:0], qm1_r}, m_r);
    a_shift_s   = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
    q_shift_s   = {sum_s[1:0], q_r[QW-1:2]};
    qm1_shift_s = q_r[1];
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (St) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        // A held St keeps us here, so it cannot retrigger a second run.
        if (St) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus registered Busy/Done decodes of the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      Busy    <= (state_nxt_s == RUN);
      Done    <= (state_nxt_s == DONE);
    end
  end

  // Datapath: operand load, iteration and result capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_r     <= {AW{1'b0}};
      m_r     <= {AW{1'b0}};
      q_r     <= {QW{1'b0}};
      qm1_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      Product <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (St) begin
            a_r   <= {AW{1'b0}};
            m_r   <= mcand_ext_s;
            q_r   <= mplier_ext_s;
            qm1_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
          end
        end
        RUN: begin
          a_r   <= a_shift_s;
          q_r   <= q_shift_s;
          qm1_r <= qm1_shift_s;
          cnt_r <= cnt_r + CNT_ONE;
          // After the last shift the low 2*WIDTH bits of {A,Q} are the product.
          if (cnt_r == CNT_LAST) begin
            Product <= {a_shift_s[WIDTH-3:0], q_shift_s};
          end
        end
        default: begin
          // DONE: everything holds.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Testbench for seq_booth_mult: directed WIDTH=16 vector table with latency,
// busy and mode-latch checks, multi-cycle handshake/reset sequences, and a
// random sweep over WIDTH=4/8/32 instances against a reference product.
module tb_seq_booth_mult;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        St;
  logic        Signed;
  logic [15:0] Mplier;
  logic [15:0] Mcand;
  logic        Busy;
  logic        Done;
  logic [31:0] Product;

  seq_booth_mult #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .St(St), .Signed(Signed),
    .Mplier(Mplier), .Mcand(Mcand),
    .Busy(Busy), .Done(Done), .Product(Product)
  );

  // Sweep instances share a start and mode line.
  logic        sw_st;
  logic        sw_sgn;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        busy4, done4, busy8, done8, busy32, done32;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [63:0] p32;

  seq_booth_mult #(.WIDTH(4)) u4 (
    .CLK(CLK), .RST(RST), .St(sw_st), .Signed(sw_sgn),
    .Mplier(a4), .Mcand(b4), .Busy(busy4), .Done(done4), .Product(p4)
  );
  seq_booth_mult #(.WIDTH(8)) u8 (
    .CLK(CLK), .RST(RST), .St(sw_st), .Signed(sw_sgn),
    .Mplier(a8), .Mcand(b8), .Busy(busy8), .Done(done8), .Product(p8)
  );
  seq_booth_mult #(.WIDTH(32)) u32 (
    .CLK(CLK), .RST(RST), .St(sw_st), .Signed(sw_sgn),
    .Mplier(a32), .Mcand(b32), .Busy(busy32), .Done(done32), .Product(p32)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sgn;
    logic [15:0] mp;
    logic [15:0] mc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference product of WIDTH-w operands, reduced to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m, m2, ea, eb;
    m  = (64'd1 << w) - 64'd1;
    m2 = (64'd1 << (2*w)) - 64'd1;
    ea = {32'd0, a} & m;
    eb = {32'd0, b} & m;
    if (sgn && ea[w-1]) ea = ea | ~m;
    if (sgn && eb[w-1]) eb = eb | ~m;
    return (ea * eb) & m2;
  endfunction

  function automatic logic [31:0] corner(input int w, input int k);
    logic [31:0] v;
    case (k)
      0:       v = 32'd0;
      1:       v = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      default: v = 32'd1 << (w - 1);
    endcase
    return v;
  endfunction

  // Start a WIDTH=16 multiply; scrambles Signed and operands during RUN.
  task automatic do_mul(input logic sgn, input logic [15:0] mp, input logic [15:0] mc,
                        output int lat, output int busy_cycles, output bit overlap);
    Signed = sgn; Mplier = mp; Mcand = mc; St = 1'b1;
    @(posedge CLK); #1;
    St = 1'b0; Signed = ~sgn; Mplier = ~mp; Mcand = mc ^ 16'h5A5A;
    lat = 0;
    busy_cycles = Busy ? 1 : 0;
    overlap = 1'b0;
    while (!Done && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (Busy) busy_cycles++;
      if (Busy && Done) overlap = 1'b1;
    end
  endtask

  task automatic sweep(input logic sgn,
                       input logic [31:0] x4, input logic [31:0] y4,
                       input logic [31:0] x8, input logic [31:0] y8,
                       input logic [31:0] x32, input logic [31:0] y32);
    bit s4, s8, s32;
    int n;
    sw_sgn = sgn;
    a4 = x4[3:0];  b4 = y4[3:0];
    a8 = x8[7:0];  b8 = y8[7:0];
    a32 = x32;     b32 = y32;
    sw_st = 1'b1;
    @(posedge CLK); #1;
    sw_st = 1'b0;
    s4 = 1'b0; s8 = 1'b0; s32 = 1'b0; n = 0;
    while (!(s4 && s8 && s32) && n < 40) begin
      @(posedge CLK); #1;
      n++;
      if (done4)  s4  = 1'b1;
      if (done8)  s8  = 1'b1;
      if (done32) s32 = 1'b1;
    end
    chk("sweep_done_seen", {61'd0, s4, s8, s32}, 64'd7);
    chk("sweep_w4",  64'(p4),  ref_mul(4,  sgn, x4,  y4));
    chk("sweep_w8",  64'(p8),  ref_mul(8,  sgn, x8,  y8));
    chk("sweep_w32", p32,      ref_mul(32, sgn, x32, y32));
    @(posedge CLK); #1;
  endtask

  initial begin
    int lat, bc;
    bit ov;
    logic [31:0] held;

    vecs[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[1]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
    vecs[2]  = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF};
    vecs[3]  = '{1'b1, 16'h8000, 16'h7FFF, 32'hC0008000};
    vecs[4]  = '{1'b0, 16'h8000, 16'h0002, 32'h00010000};
    vecs[5]  = '{1'b1, 16'h8000, 16'h0002, 32'hFFFF0000};
    vecs[6]  = '{1'b1, 16'h0007, 16'hFFFD, 32'hFFFFFFEB};
    vecs[7]  = '{1'b0, 16'h0003, 16'h0005, 32'h0000000F};
    vecs[8]  = '{1'b0, 16'h1234, 16'h0000, 32'h00000000};
    vecs[9]  = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[10] = '{1'b0, 16'hABCD, 16'h1234, 32'h0C374FA4};
    vecs[11] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};

    RST = 1'b1; St = 1'b0; Signed = 1'b0; Mplier = 16'h0; Mcand = 16'h0;
    sw_st = 1'b0; sw_sgn = 1'b0;
    a4 = 4'h0; b4 = 4'h0; a8 = 8'h0; b8 = 8'h0; a32 = 32'h0; b32 = 32'h0;
    #12;
    chk("reset_busy",    64'(Busy),    64'd0);
    chk("reset_done",    64'(Done),    64'd0);
    chk("reset_product", 64'(Product), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Directed table: result, latency, busy length, exclusivity, hold in IDLE.
    for (int i = 0; i < 12; i++) begin
      do_mul(vecs[i].sgn, vecs[i].mp, vecs[i].mc, lat, bc, ov);
      chk($sformatf("vec%0d_product", i), 64'(Product), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd9);
      chk($sformatf("vec%0d_busy_done_overlap", i), 64'(ov), 64'd0);
      Mplier = 16'h0F0F; Mcand = 16'hF0F0;
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_done_cleared", i), 64'(Done), 64'd0);
      chk($sformatf("vec%0d_product_held", i), 64'(Product), 64'(vecs[i].exp));
    end

    // St held high through completion: DONE persists, no second run.
    Signed = 1'b0; Mplier = 16'h1234; Mcand = 16'h0010; St = 1'b1;
    @(posedge CLK); #1;
    lat = 0;
    while (!Done && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("hold_latency", 64'(lat), 64'd9);
    chk("hold_product", 64'(Product), 64'h12340);
    repeat (5) @(posedge CLK);
    #1;
    chk("hold_done_persist", 64'(Done), 64'd1);
    chk("hold_no_rerun",     64'(Busy), 64'd0);
    St = 1'b0;
    @(posedge CLK); #1;
    chk("hold_drop_done", 64'(Done), 64'd0);
    chk("hold_drop_busy", 64'(Busy), 64'd0);
    Mplier = 16'd3; Mcand = 16'd5; St = 1'b1;
    @(posedge CLK); #1;
    St = 1'b0;
    chk("rearm_busy", 64'(Busy), 64'd1);
    repeat (4) @(posedge CLK);
    #1;
    chk("rearm_prev_product_visible", 64'(Product), 64'h12340);
    lat = 0;
    while (!Done && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("rearm_product", 64'(Product), 64'd15);
    @(posedge CLK); #1;

    // Asynchronous reset mid-run, then a normal signed multiply.
    Signed = 1'b0; Mplier = 16'hFFFF; Mcand = 16'hFFFF; St = 1'b1;
    @(posedge CLK); #1;
    St = 1'b0;
    repeat (4) @(posedge CLK);
    #3;
    chk("prerst_busy", 64'(Busy), 64'd1);
    RST = 1'b1;
    #1;
    chk("midrst_busy",    64'(Busy),    64'd0);
    chk("midrst_done",    64'(Done),    64'd0);
    chk("midrst_product", 64'(Product), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("postrst_idle_busy", 64'(Busy), 64'd0);
    do_mul(1'b1, 16'd7, 16'hFFFD, lat, bc, ov);
    chk("postrst_product", 64'(Product), 64'hFFFFFFEB);
    chk("postrst_latency", 64'(lat), 64'd9);
    @(posedge CLK); #1;

    // Corner sweep over widths 4/8/32, both modes.
    for (int s = 0; s < 2; s++) begin
      for (int ka = 0; ka < 3; ka++) begin
        for (int kb = 0; kb < 3; kb++) begin
          sweep(s[0], corner(4, ka), corner(4, kb), corner(8, ka), corner(8, kb),
                corner(32, ka), corner(32, kb));
        end
      end
    end

    // Random sweep.
    for (int r = 0; r < 40; r++) begin
      sweep(r[0], $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
    end

    held = Product;
    chk("sweep_main_product_untouched", 64'(held), 64'hFFFFFFEB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
